// File: rtl/osd_cmd_sched.sv
// osd_cmd_sched: two-requester round-robin scheduler serialising show/hide and tile-write OSD commands.
// Optional auto-hide after AUTOHIDE_FRAMES vsync edges is enabled by defining OSD_AUTOHIDE_EN.
module osd_cmd_sched #(
    parameter int GAP             = 1,
    parameter int AUTOHIDE_FRAMES = 300
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        a_req,
    input  logic        a_kind,
    input  logic        a_en,
    input  logic [6:0]  a_tile,
    input  logic [63:0] a_data,
    output logic        a_ack,
    input  logic        b_req,
    input  logic        b_kind,
    input  logic        b_en,
    input  logic [6:0]  b_tile,
    input  logic [63:0] b_data,
    output logic        b_ack,
    input  logic        vs,
    output logic        osd_strobe,
    output logic        osd_start,
    output logic [7:0]  osd_data,
    output logic        busy
);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
    logic           kind_q, kind_d, en_q, en_d, who_q, who_d, inj_q, inj_d, pref_b_q, pref_b_d;
    logic [6:0]     tile_q, tile_d;
    logic [63:0]    data_q, data_d;
    logic           inject, any_req, pick_b, last_byte;
    logic [2:0]     byte_idx;
    logic [7:0]     cur_byte;

`ifdef OSD_AUTOHIDE_EN
    localparam logic [15:0] AH_LIM = 16'(AUTOHIDE_FRAMES);
    logic        shown_q, shown_d, vs_q;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = (state_q == S_DONE) ? 16'd0 :
                  (vs && !vs_q && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        shown_d = (state_q == S_DONE && !kind_q) ? en_q : shown_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shown_q <= 1'b0;
            vs_q    <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            shown_q <= shown_d;
            vs_q    <= vs;
            cnt_q   <= cnt_d;
        end
    end

    assign inject = shown_q && (cnt_q >= AH_LIM);
`else
    localparam int unused_ah = AUTOHIDE_FRAMES;
    logic unused_vs;
    assign unused_vs = vs;
    assign inject    = 1'b0;
`endif

    // Auto-hide outranks both requesters; between A and B the previous loser wins.
    assign any_req   = a_req || b_req || inject;
    assign pick_b    = !inject && b_req && (!a_req || pref_b_q);
    assign last_byte = idx_q == (kind_q ? 4'd9 : 4'd1);
    assign byte_idx  = 3'(idx_q - 4'd2);
    assign cur_byte  = (idx_q == 4'd0) ? (kind_q ? 8'h02 : 8'h01) :
                       (idx_q == 4'd1) ? (kind_q ? {1'b0, tile_q} : {7'b0, en_q}) :
                       data_q[{byte_idx, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = any_req ? S_SEND : S_IDLE;
            S_SEND:  state_d = last_byte ? S_DONE : (GAP == 0) ? S_SEND : S_GAP;
            S_GAP:   state_d = (gap_cnt_q == GAP_LAST) ? S_SEND : S_GAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        osd_strobe = state_q == S_SEND;
        osd_start  = osd_strobe && idx_q == 4'd0;
        osd_data   = osd_strobe ? cur_byte : 8'h00;
        a_ack      = state_q == S_DONE && !inj_q && !who_q;
        b_ack      = state_q == S_DONE && !inj_q && who_q;
        busy       = state_q != S_IDLE || (reset_n && any_req);
    end

    always_comb begin
        kind_d    = kind_q;
        en_d      = en_q;
        tile_d    = tile_q;
        data_d    = data_q;
        who_d     = who_q;
        inj_d     = inj_q;
        pref_b_d  = pref_b_q;
        idx_d     = (state_q == S_SEND) ? idx_q + 4'd1 : idx_q;
        gap_cnt_d = (state_q == S_GAP) ? gap_cnt_q + GW'(1) : '0;
        if (state_q == S_IDLE && any_req) begin
            kind_d   = !inject && (pick_b ? b_kind : a_kind);
            en_d     = !inject && (pick_b ? b_en : a_en);
            tile_d   = pick_b ? b_tile : a_tile;
            data_d   = pick_b ? b_data : a_data;
            who_d    = pick_b;
            inj_d    = inject;
            pref_b_d = inject ? pref_b_q : !pick_b;
            idx_d    = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q     <= 4'd0;
            gap_cnt_q <= '0;
            kind_q    <= 1'b0;
            en_q      <= 1'b0;
            tile_q    <= 7'd0;
            data_q    <= 64'd0;
            who_q     <= 1'b0;
            inj_q     <= 1'b0;
            pref_b_q  <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            gap_cnt_q <= gap_cnt_d;
            kind_q    <= kind_d;
            en_q      <= en_d;
            tile_q    <= tile_d;
            data_q    <= data_d;
            who_q     <= who_d;
            inj_q     <= inj_d;
            pref_b_q  <= pref_b_d;
        end
    end
endmodule

// File: tb/tb_osd_cmd_sched.sv
// tb_osd_cmd_sched: directed checks of osd_cmd_sched byte sequences, arbitration, reset and auto-hide.
module tb_osd_cmd_sched;
    typedef logic [8:0] seq_t [10];

    logic        clk = 1'b0, reset_n = 1'b0, vs = 1'b0;
    logic        a_req = 1'b0, a_kind = 1'b0, a_en = 1'b0, b_req = 1'b0, b_kind = 1'b0, b_en = 1'b0, a_req2 = 1'b0;
    logic [6:0]  a_tile = '0, b_tile = '0;
    logic [63:0] a_data = '0, b_data = '0;
    logic        a_ack, b_ack, stb, st, busy, a_ack2, b_ack2, stb2, st2, busy2;
    logic [7:0]  dat, dat2;
    logic        sel = 1'b0;
    logic        m_stb, m_st, m_aack, m_back, m_busy;
    logic [7:0]  m_dat;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    osd_cmd_sched #(.GAP(1), .AUTOHIDE_FRAMES(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_kind(a_kind), .a_en(a_en), .a_tile(a_tile), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_kind(b_kind), .b_en(b_en), .b_tile(b_tile), .b_data(b_data), .b_ack(b_ack),
        .vs(vs), .osd_strobe(stb), .osd_start(st), .osd_data(dat), .busy(busy));

    osd_cmd_sched #(.GAP(0), .AUTOHIDE_FRAMES(3)) dut_g0 (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req2), .a_kind(a_kind), .a_en(a_en), .a_tile(a_tile), .a_data(a_data), .a_ack(a_ack2),
        .b_req(1'b0), .b_kind(1'b0), .b_en(1'b0), .b_tile(7'd0), .b_data(64'd0), .b_ack(b_ack2),
        .vs(1'b0), .osd_strobe(stb2), .osd_start(st2), .osd_data(dat2), .busy(busy2));

    assign m_stb  = sel ? stb2 : stb;
    assign m_st   = sel ? st2 : st;
    assign m_dat  = sel ? dat2 : dat;
    assign m_aack = sel ? a_ack2 : a_ack;
    assign m_back = sel ? b_ack2 : b_ack;
    assign m_busy = sel ? busy2 : busy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic seq_t tile_seq(input logic [6:0] t, input logic [63:0] d);
        seq_t s;
        s[0] = 9'h102;
        s[1] = {2'b00, t};
        for (int i = 0; i < 8; i++) s[i+2] = {1'b0, d[8*i +: 8]};
        return s;
    endfunction

    function automatic seq_t sh_seq(input logic en);
        seq_t s;
        for (int i = 0; i < 10; i++) s[i] = 9'h000;
        s[0] = 9'h101;
        s[1] = {8'h00, en};
        return s;
    endfunction

    // Called inside the grant cycle; returns at the ack-cycle sample point (or early before cycle `stop`).
    task automatic expect_txn(input logic is_b, input int n, input seq_t s, input int gap, input int stop, input string tag);
        logic e;
        int   bi;
        chk({tag, "_grant_busy"}, m_busy, 1);
        chk({tag, "_grant_stb"}, m_stb, 0);
        for (int k = 1; k <= (n - 1) * (gap + 1) + 1; k++) begin
            if (k == stop) return;
            @(negedge clk);
            e  = ((k - 1) % (gap + 1)) == 0;
            bi = (k - 1) / (gap + 1);
            chk($sformatf("%s_stb%0d", tag, k), m_stb, e);
            chk($sformatf("%s_start%0d", tag, k), m_st, e ? s[bi][8] : 1'b0);
            chk($sformatf("%s_data%0d", tag, k), m_dat, e ? s[bi][7:0] : 8'h00);
            chk($sformatf("%s_noack%0d", tag, k), {m_aack, m_back}, 2'b00);
            chk($sformatf("%s_busy%0d", tag, k), m_busy, 1);
        end
        @(negedge clk);
        chk({tag, "_a_ack"}, m_aack, !is_b);
        chk({tag, "_b_ack"}, m_back, is_b);
        chk({tag, "_ack_busy"}, m_busy, 1);
        chk({tag, "_ack_stb"}, m_stb, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] q[$];
        int         acks;
        #3;
        chk("rst_outputs", {stb, st, dat, busy, a_ack, b_ack}, 13'd0);
        chk("rst_outputs_g0", {stb2, st2, dat2, busy2, a_ack2}, 12'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Tile write with GAP=1: ten strobes every other cycle, ack at N+20
        a_kind = 1'b1; a_tile = 7'd5; a_data = 64'h0807060504030201; a_req = 1'b1;
        #1;
        expect_txn(1'b0, 10, tile_seq(7'd5, 64'h0807060504030201), 1, 0, "t1");
        a_req = 1'b0;
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_ack", a_ack, 0);

        // Both requesting continuously: A, B, A
        do_reset();
        a_kind = 1'b0; a_en = 1'b1; b_kind = 1'b0; b_en = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        #1;
        expect_txn(1'b0, 2, sh_seq(1'b1), 1, 0, "t2a");
        @(negedge clk);
        expect_txn(1'b1, 2, sh_seq(1'b0), 1, 0, "t2b");
        @(negedge clk);
        expect_txn(1'b0, 2, sh_seq(1'b1), 1, 0, "t2c");
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);

        // B show
        b_kind = 1'b0; b_en = 1'b1; b_req = 1'b1;
        #1;
        expect_txn(1'b1, 2, sh_seq(1'b1), 1, 0, "t3");
        b_req = 1'b0;
        @(negedge clk);
        chk("t3_after_back", b_ack, 0);
        chk("t3_after_busy", busy, 0);

        // Reset during the 4th tile byte, then full resend with a single ack
        a_kind = 1'b1; a_tile = 7'd7; a_data = 64'h1122334455667788; a_req = 1'b1;
        #1;
        expect_txn(1'b0, 10, tile_seq(7'd7, 64'h1122334455667788), 1, 11, "t4pre");
        @(posedge clk);
        #2;
        chk("t4_mid_stb", stb, 1);
        chk("t4_mid_data", dat, 8'h55);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_outputs", {stb, st, dat, busy, a_ack, b_ack}, 13'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        expect_txn(1'b0, 10, tile_seq(7'd7, 64'h1122334455667788), 1, 0, "t4");
        a_req = 1'b0;
        @(negedge clk);
        chk("t4_single_ack", a_ack, 0);

        // Auto-hide: show, then three vs rising edges
        a_kind = 1'b0; a_en = 1'b1; a_req = 1'b1;
        #1;
        expect_txn(1'b0, 2, sh_seq(1'b1), 1, 0, "t5show");
        a_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (stb) q.push_back({st, dat});
            acks += int'(a_ack) + int'(b_ack);
            vs = (i < 6) && (i % 2 == 0);
        end
`ifdef OSD_AUTOHIDE_EN
        chk("t5_nstb", q.size(), 2);
        if (q.size() == 2) begin
            chk("t5_byte0", q[0], 9'h101);
            chk("t5_byte1", q[1], 9'h000);
        end
`else
        chk("t5_nstb", q.size(), 0);
`endif
        chk("t5_acks", acks, 0);

        // GAP=0 instance: ten back-to-back strobes, ack at N+11
        sel = 1'b1;
        a_kind = 1'b1; a_tile = 7'd9; a_data = 64'hA5B6C7D8E9FA0B1C; a_req2 = 1'b1;
        #1;
        expect_txn(1'b0, 10, tile_seq(7'd9, 64'hA5B6C7D8E9FA0B1C), 0, 0, "t6");
        a_req2 = 1'b0;
        @(negedge clk);
        chk("t6_idle_busy", busy2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
